// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM encoding and default widths.
// The optional response watchdog is enabled with the MEM_ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the arbiter.
// Modport master is the arbiter itself, slave is the environment around it.
interface mem_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  // Requester side: req_ready[i] is a one-cycle accept while req_valid[i] is high;
  // resp_valid[i] is a one-cycle pulse. Memory side: mem_req_valid stays high with a
  // stable payload until the cycle mem_req_ready is seen; mem_resp_valid is a pulse.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_resp_valid;
  logic [DATA_W-1:0]         mem_resp_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit after last_grant, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..NUM_REQ so last_grant itself is searched last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters, one transaction
// outstanding. Define MEM_ARB_TIMEOUT_EN to add the response watchdog (resp_err).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arb_if.master  bus,
  output logic [1:0] dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("mem_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT 1..65535");
  end

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
`ifdef MEM_ARB_TIMEOUT_EN
  logic               err_q;
  logic [15:0]        to_cnt;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Grant is combinational in IDLE; held at zero while reset is asserted.
  assign bus.req_ready     = (state == ST_IDLE && rst_n) ? pick_grant : '0;
  assign bus.mem_req_valid = (state == ST_ISSUE);
  assign bus.mem_we        = lat_we;
  assign bus.mem_addr      = lat_addr;
  assign bus.mem_wdata     = lat_wdata;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = rdata_q;
  assign dbg_state         = state;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.resp_err      = err_q;
`else
  assign bus.resp_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      cur          <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
      to_cnt       <= '0;
`endif
    end else begin
      resp_valid_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            cur       <= pick_idx;
            lat_we    <= bus.req_we[pick_idx];
            lat_addr  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
            lat_wdata <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Rotation pointer only advances once the slave has taken the request.
          if (bus.mem_req_ready) begin
            last_grant <= cur;
            state      <= ST_WAIT_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        ST_WAIT_RESP: begin
          if (bus.mem_resp_valid) begin
            resp_valid_q[cur] <= 1'b1;
            rdata_q           <= bus.mem_resp_rdata;
            state             <= ST_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q             <= 1'b0;
          end else if (to_cnt == 16'(TIMEOUT - 1)) begin
            // Decided one cycle early so the registered pulse lands TIMEOUT cycles in.
            resp_valid_q[cur] <= 1'b1;
            rdata_q           <= '0;
            err_q             <= 1'b1;
            state             <= ST_IDLE;
          end else begin
            to_cnt            <= to_cnt + 16'd1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fairness, single read, stray response,
// backpressure, async reset mid-transaction and, with MEM_ARB_TIMEOUT_EN, the watchdog.
module tb_mem_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  mem_arb_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int         grants;
  int         cyc;
  int         last_cyc;
  int         pulses;
  logic       acc;
  logic [3:0] exp_g;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_state", dbg_state, 0);

    // Fairness: all four valid, zero-wait slave answering the cycle after accept.
    next_cycle();
    for (int i = 0; i < NR; i++) bus.req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
    bus.req_valid = 4'b1111;
    bus.mem_req_ready = 1'b1;
    grants = 0;
    cyc = 0;
    last_cyc = 0;
    acc = 1'b0;
    while (grants < 12 && cyc < 100) begin
      #2;
      if (bus.req_ready != 0) begin
        exp_g = 4'b0001 << (grants % NR);
        chk("fair_grant", bus.req_ready, exp_g);
        // Window from one grant cycle to the next, both inclusive.
        if (grants > 0) chk("fair_turnaround", cyc - last_cyc + 1, 4);
        last_cyc = cyc;
        grants++;
      end
      acc = bus.mem_req_valid && bus.mem_req_ready;
      next_cycle();
      cyc++;
      bus.mem_resp_valid = acc;
      bus.mem_resp_rdata = 32'(cyc);
    end
    chk("fair_grant_count", grants, 12);
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      #2;
      acc = bus.mem_req_valid && bus.mem_req_ready;
      next_cycle();
      bus.mem_resp_valid = acc;
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("fair_drained_idle", dbg_state, 0);

    // Single read from requester 2, slave answers two cycles after accept.
    next_cycle();
    bus.req_valid = 4'b0100;
    bus.req_we = 4'b0000;
    bus.req_addr[2*AW +: AW] = 32'h100;
    #2;
    chk("rd_req_ready", bus.req_ready, 4'b0100);
    next_cycle();
    bus.req_valid = '0;
    bus.mem_req_ready = 1'b1;
    #2;
    chk("rd_mem_req_valid", bus.mem_req_valid, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h100);
    chk("rd_mem_we", bus.mem_we, 0);
    next_cycle();
    bus.mem_req_ready = 1'b0;
    #2;
    chk("rd_valid_dropped", bus.mem_req_valid, 0);
    next_cycle();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hDEADBEEF;
    #2;
    chk("rd_no_early_resp", bus.resp_valid, 0);
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("rd_resp_valid", bus.resp_valid, 4'b0100);
    chk("rd_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);
    chk("rd_resp_err", bus.resp_err, 0);
    next_cycle();
    #2;
    chk("rd_resp_pulse_end", bus.resp_valid, 0);
    chk("rd_rdata_held", bus.resp_rdata, 32'hDEADBEEF);

    // Stray response while idle is ignored.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1234;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("stray_resp_valid", bus.resp_valid, 0);
    chk("stray_rdata_held", bus.resp_rdata, 32'hDEADBEEF);
    chk("stray_state", dbg_state, 0);

    // Backpressure on a write from requester 1: ready low 5 cycles, high on the 6th.
    next_cycle();
    bus.req_valid = 4'b0010;
    bus.req_we = 4'b0010;
    bus.req_addr[1*AW +: AW] = 32'h40;
    bus.req_wdata[1*DW +: DW] = 32'h55AA;
    #2;
    chk("bp_req_ready", bus.req_ready, 4'b0010);
    next_cycle();
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.mem_req_ready = 1'b1;
      #2;
      chk("bp_mem_req_valid", bus.mem_req_valid, 1);
      chk("bp_mem_addr", bus.mem_addr, 32'h40);
      chk("bp_mem_wdata", bus.mem_wdata, 32'h55AA);
      chk("bp_mem_we", bus.mem_we, 1);
      next_cycle();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("bp_ack_resp", bus.resp_valid, 4'b0010);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #2;
      if (bus.resp_valid != 0) pulses++;
    end
    chk("bp_single_resp", pulses, 0);

    // Reset while waiting on requester 3's response, then a 0-vs-3 tie.
    next_cycle();
    bus.req_valid = 4'b1000;
    bus.req_addr[3*AW +: AW] = 32'h77;
    bus.req_wdata[3*DW +: DW] = 32'h99;
    #2;
    chk("rst_mid_grant", bus.req_ready, 4'b1000);
    next_cycle();
    bus.req_valid = '0;
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    #2;
    chk("rst_mid_in_wait", dbg_state, 2);
    bus.req_valid = 4'b1001;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", bus.req_ready, 0);
    chk("rst_mid_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_mid_mem_addr", bus.mem_addr, 0);
    chk("rst_mid_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mid_resp_valid", bus.resp_valid, 0);
    chk("rst_mid_resp_rdata", bus.resp_rdata, 0);
    chk("rst_mid_state", dbg_state, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #2;
    chk("tie_after_reset", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = '0;
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFE;
    next_cycle();
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("tie_resp_valid", bus.resp_valid, 4'b0001);
    chk("tie_resp_rdata", bus.resp_rdata, 32'hCAFE);

`ifdef MEM_ARB_TIMEOUT_EN
    // Slave never answers: error response exactly 10 cycles after entering WAIT_RESP.
    next_cycle();
    bus.req_valid = 4'b0100;
    next_cycle();
    bus.req_valid = '0;
    bus.mem_req_ready = 1'b1;
    next_cycle();
    bus.mem_req_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      #2;
      chk("to_resp_valid", bus.resp_valid, (k == 10) ? 4'b0100 : 4'b0000);
    end
    chk("to_resp_err", bus.resp_err, 1);
    chk("to_resp_rdata", bus.resp_rdata, 0);
    next_cycle();
    bus.req_valid = 4'b0001;
    #2;
    chk("to_next_grant", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = '0;
`endif

    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
